// File: rtl/vgpr_bank_nr_1w.sv
// Vector register bank: NUM_RD registered read ports with write-first bypass and one
// multi-dword write port that retires up to 4 dwords, one per cycle, with address wrap.
module vgpr_bank_nr_1w #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 1024,
    parameter int ADDR_W       = 10,
    parameter int NUM_RD       = 3,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [3:0]                 wr_en,
    input  logic [4*DATA_W-1:0]        wr_data,
    output logic                       init_done
);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   addr_ext_t;
    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_BURST} state_t;

    localparam addr_ext_t DEPTH_EXT = addr_ext_t'(DEPTH);
    localparam addr_t     LAST_IDX  = addr_t'(DEPTH - 1);

    state_t                  state;
    addr_t                   clr_cnt;
    addr_t                   pend_addr;
    logic [3:0]              pend_en;
    logic [4*DATA_W-1:0]     pend_data;
    logic [DATA_W-1:0]       mem [DEPTH];

    logic                    accept;
    logic [1:0]              acc_idx;
    logic [1:0]              burst_idx;
    logic [3:0]              acc_rest;
    logic [3:0]              burst_rest;
    logic                    mem_we;
    addr_t                   mem_waddr;
    logic [DATA_W-1:0]       mem_wdata;

    function automatic logic [1:0] lowest_idx(input logic [3:0] en);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (en[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic addr_t wrap_add(input addr_t base, input logic [1:0] off);
        addr_ext_t sum;
        sum = {1'b0, base} + addr_ext_t'(off);
        if (sum >= DEPTH_EXT) sum = sum - DEPTH_EXT;
        return sum[ADDR_W-1:0];
    endfunction

    function automatic logic in_range(input addr_t a);
        return addr_ext_t'(a) < DEPTH_EXT;
    endfunction

    // Single physical write port, shared by the clear sweep, the accept edge and BURST.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        accept     = wr_valid && wr_ready && (state == ST_IDLE);
        acc_idx    = lowest_idx(wr_en);
        burst_idx  = lowest_idx(pend_en);
        acc_rest   = wr_en & ~(4'b0001 << acc_idx);
        burst_rest = pend_en & ~(4'b0001 << burst_idx);
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        case (state)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
            end
            ST_IDLE: begin
                if (accept && (wr_en != 4'b0000)) begin
                    mem_we    = 1'b1;
                    mem_waddr = wrap_add(wr_addr, acc_idx);
                    mem_wdata = wr_data[acc_idx*DATA_W +: DATA_W];
                end
            end
            ST_BURST: begin
                mem_we    = (pend_en != 4'b0000);
                mem_waddr = wrap_add(pend_addr, burst_idx);
                mem_wdata = pend_data[burst_idx*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt   <= '0;
            pend_en   <= 4'b0000;
            pend_addr <= '0;
            pend_data <= '0;
            wr_ready  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_IDX) begin
                        state     <= ST_IDLE;
                        wr_ready  <= 1'b1;
                        init_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    wr_ready  <= 1'b1;
                    init_done <= 1'b1;
                    if (accept && (acc_rest != 4'b0000)) begin
                        pend_en   <= acc_rest;
                        pend_addr <= wr_addr;
                        pend_data <= wr_data;
                        state     <= ST_BURST;
                        wr_ready  <= 1'b0;
                    end
                end
                ST_BURST: begin
                    pend_en <= burst_rest;
                    if (burst_rest == 4'b0000) begin
                        state    <= ST_IDLE;
                        wr_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the storage array has no reset; only the clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (!rst && mem_we && in_range(mem_waddr)) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        addr_t ra;
        assign ra = rd_addr[p*ADDR_W +: ADDR_W];

        always_ff @(posedge clk) begin
            if (rst || state == ST_CLEAR || !in_range(ra)) begin
                rd_data[p*DATA_W +: DATA_W] <= '0;
            end else if (mem_we && mem_waddr == ra) begin
                rd_data[p*DATA_W +: DATA_W] <= mem_wdata;
            end else begin
                rd_data[p*DATA_W +: DATA_W] <= mem[ra];
            end
        end
    end

endmodule

// File: tb/tb_vgpr_bank_nr_1w.sv
// Directed bench for vgpr_bank_nr_1w: read-vector table plus hand-written burst,
// bypass and reset sequences with hand-computed expectations.
module tb_vgpr_bank_nr_1w;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int NR    = 3;
    localparam int DEPTH = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [AW-1:0]     wr_addr;
    logic [3:0]        wr_en;
    logic [4*DW-1:0]   wr_data;
    logic              init_done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [NR-1:0][AW-1:0] addr;
        logic [NR-1:0][DW-1:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [7];

    vgpr_bank_nr_1w #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NUM_RD(NR), .CLEAR_ON_RST(1)
    ) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_en(wr_en), .wr_data(wr_data), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic rd_vec_t mk(input int a0, input int a1, input int a2,
                                   input logic [31:0] e0, input logic [31:0] e1,
                                   input logic [31:0] e2);
        rd_vec_t v;
        v.addr[0] = AW'(a0); v.addr[1] = AW'(a1); v.addr[2] = AW'(a2);
        v.exp[0]  = e0;      v.exp[1]  = e1;      v.exp[2]  = e2;
        return v;
    endfunction

    function automatic logic [31:0] rd(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    task automatic set_rd(input int a0, input int a1, input int a2);
        rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rd_addr = vecs[i].addr;
            tick();
            for (int p = 0; p < NR; p++) begin
                check($sformatf("vec%0d_port%0d", i, p), rd(p), vecs[i].exp[p]);
            end
        end
    endtask

    task automatic accept_write(input int addr, input logic [3:0] en,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3);
        wr_addr  = AW'(addr);
        wr_en    = en;
        wr_data  = {d3, d2, d1, d0};
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int exp_low);
        int cnt = 0;
        while (!wr_ready && cnt < 50) begin
            tick();
            cnt++;
        end
        check(name, 32'(cnt), 32'(exp_low));
    endtask

    task automatic wait_clear(input string name);
        int cnt = 0;
        while (!wr_ready && cnt < 2000) begin
            tick();
            cnt++;
        end
        check({name, "_cycles"}, 32'(cnt), 32'(DEPTH));
        check({name, "_init_done"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        vecs[0] = mk(0, 511, 1023, 32'h0, 32'h0, 32'h0);
        vecs[1] = mk(5, 1022, 1023, 32'hDEADBEEF, 32'hA0, 32'hA1);
        vecs[2] = mk(0, 1, 4, 32'hA2, 32'hA3, 32'h0);
        vecs[3] = mk(16, 17, 18, 32'hC0, 32'hB1, 32'hC2);
        vecs[4] = mk(19, 20, 15, 32'hB3, 32'h0, 32'h0);
        vecs[5] = mk(40, 41, 42, 32'h0, 32'h0, 32'h0);
        vecs[6] = mk(43, 5, 1022, 32'h0, 32'h0, 32'h0);

        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_en = '0; wr_data = '0; rd_addr = '0;
        tick();
        tick();
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_rd_data0", rd(0), 32'h0);
        rst = 1'b0;
        wait_clear("clear");
        run_vectors(0, 0);

        // Single-dword write, then read back one cycle later.
        accept_write(5, 4'b0001, 32'hDEADBEEF, 32'h1, 32'h2, 32'h3);
        check("single_wr_ready", 32'(wr_ready), 32'd1);
        set_rd(5, 0, 0);
        tick();
        check("single_readback", rd(0), 32'hDEADBEEF);

        // Full wrapping burst with bypass on the BURST write edges.
        accept_write(1022, 4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        check("burst_ready_a", 32'(wr_ready), 32'd0);
        set_rd(1023, 1023, 1023);
        tick();
        for (int p = 0; p < NR; p++) check($sformatf("bypass_port%0d", p), rd(p), 32'hA1);
        check("burst_ready_b1", 32'(wr_ready), 32'd0);
        set_rd(5, 0, 1023);
        tick();
        check("bypass_unrelated", rd(0), 32'hDEADBEEF);
        check("bypass_wrap0", rd(1), 32'hA2);
        check("bypass_stored", rd(2), 32'hA1);
        check("burst_ready_b2", 32'(wr_ready), 32'd0);
        tick();
        check("burst_ready_b3", 32'(wr_ready), 32'd1);
        run_vectors(1, 2);

        // Pre-fill 16/18, then a sparse write to 17/19 that must leave them alone.
        accept_write(16, 4'b0101, 32'hC0, 32'hC1, 32'hC2, 32'hC3);
        wait_ready("prefill_low", 1);
        accept_write(16, 4'b1010, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
        wait_ready("sparse_low", 1);
        accept_write(20, 4'b0000, 32'hEE, 32'hEE, 32'hEE, 32'hEE);
        check("noop_wr_ready", 32'(wr_ready), 32'd1);
        run_vectors(3, 4);

        // Reset on the second BURST cycle abandons the rest and restarts the clear.
        accept_write(40, 4'b1111, 32'hD0, 32'hD1, 32'hD2, 32'hD3);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_wr_ready", 32'(wr_ready), 32'd0);
        check("midrst_init_done", 32'(init_done), 32'd0);
        check("midrst_rd_data", rd(0), 32'h0);
        rst = 1'b0;
        wait_clear("reclear");
        run_vectors(5, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
